// File: rtl/usb_fs_tx_driver.sv
// USB full-speed transmit line driver: SYNC, NRZI-encoded bit-stuffed data, EOP.
// Outputs are registered; each clock edge selects the line bit for the following cycle.
module usb_fs_tx_driver (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_dp,
  output logic       o_dn,
  output logic       o_oe,
  output logic       o_busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_EOP1 = 3'd3;
  localparam logic [2:0] ST_EOP2 = 3'd4;
  localparam logic [2:0] ST_EOPJ = 3'd5;

  // r_level: 1 = J, 0 = K. r_cnt indexes the bit being (or next to be) sent.
  logic [2:0] r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_sr;
  logic [2:0] r_ones;
  logic       r_level;
  logic       r_stuff;
  logic       r_eop_pend;
  logic       r_ready;
  logic       r_dp;
  logic       r_dn;
  logic       r_oe;
  logic       r_busy;

  logic [2:0] w_state;
  logic [2:0] w_cnt;
  logic [7:0] w_sr;
  logic [2:0] w_ones;
  logic       w_level;
  logic       w_stuff;
  logic       w_eop_pend;
  logic       w_ready;
  logic       w_emit;
  logic       w_bit;
  logic       w_eop_req;
  logic       w_go_eop;
  logic       w_se0;

  // Next-bit selection: SYNC/data bit, stuffed toggle, or EOP sequencing.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_sr       = r_sr;
    w_ones     = r_ones;
    w_level    = r_level;
    w_stuff    = 1'b0;
    w_eop_pend = r_eop_pend;
    w_ready    = 1'b0;
    w_emit     = 1'b0;
    w_bit      = 1'b0;
    w_eop_req  = 1'b0;
    w_go_eop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_level    = 1'b1;
        w_ones     = 3'd0;
        w_eop_pend = 1'b0;
        if (i_tx_valid) begin
          w_state = ST_SYNC;
          w_cnt   = 3'd0;
          w_emit  = 1'b1;
          w_bit   = 1'b0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (r_stuff) begin
          // Data position was already advanced when the stuff was scheduled.
          if (r_eop_pend) begin
            w_go_eop = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_bit  = (r_state == ST_SYNC) ? (r_cnt == 3'd7) : r_sr[0];
          end
        end else begin
          if (r_cnt == 3'd7) begin
            if (i_tx_valid) begin
              w_state = ST_DATA;
              w_cnt   = 3'd0;
              w_sr    = i_tx_data;
            end else begin
              w_eop_req = 1'b1;
            end
          end else begin
            w_cnt = r_cnt + 3'd1;
            if (r_state == ST_DATA) begin
              w_sr = {1'b0, r_sr[7:1]};
            end else begin
              w_sr = r_sr;
            end
          end
          if (r_ones == 3'd6) begin
            w_stuff    = 1'b1;
            w_level    = ~r_level;
            w_ones     = 3'd0;
            w_eop_pend = w_eop_req;
          end else if (w_eop_req) begin
            w_go_eop = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_bit  = (w_state == ST_SYNC) ? (w_cnt == 3'd7) : w_sr[0];
          end
        end
      end
      ST_EOP1: w_state = ST_EOP2;
      ST_EOP2: w_state = ST_EOPJ;
      ST_EOPJ: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase

    if (w_emit) begin
      w_level = w_bit ? r_level : ~r_level;
      w_ones  = w_bit ? (r_ones + 3'd1) : 3'd0;
      w_ready = (w_cnt == 3'd7);
    end else begin
      w_ready = 1'b0;
    end

    if (w_go_eop) begin
      w_state    = ST_EOP1;
      w_level    = 1'b1;
      w_ones     = 3'd0;
      w_eop_pend = 1'b0;
    end else begin
      w_eop_pend = w_eop_pend;
    end

    w_se0 = (w_state == ST_EOP1) || (w_state == ST_EOP2);
  end

  // State and registered line outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_sr       <= 8'd0;
      r_ones     <= 3'd0;
      r_level    <= 1'b1;
      r_stuff    <= 1'b0;
      r_eop_pend <= 1'b0;
      r_ready    <= 1'b0;
      r_dp       <= 1'b1;
      r_dn       <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_sr       <= w_sr;
      r_ones     <= w_ones;
      r_level    <= w_level;
      r_stuff    <= w_stuff;
      r_eop_pend <= w_eop_pend;
      r_ready    <= w_ready;
      r_dp       <= w_se0 ? 1'b0 : w_level;
      r_dn       <= w_se0 ? 1'b0 : ~w_level;
      r_oe       <= (w_state != ST_IDLE);
      r_busy     <= (w_state != ST_IDLE);
    end
  end

  assign o_tx_ready = r_ready;
  assign o_dp       = r_dp;
  assign o_dn       = r_dn;
  assign o_oe       = r_oe;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_usb_fs_tx_driver.sv
// Directed bench for usb_fs_tx_driver: line symbols and ready pulses against hand-computed strings.
module tb_usb_fs_tx_driver;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       dp;
  logic       dn;
  logic       oe;
  logic       busy;

  int n_checks;
  int n_errors;

  usb_fs_tx_driver dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_valid (tx_valid),
    .i_tx_data  (tx_data),
    .o_tx_ready (tx_ready),
    .o_dp       (dp),
    .o_dn       (dn),
    .o_oe       (oe),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string got, input string exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %s expected %s", tag, got, exp);
    end
  endtask

  function automatic string status();
    return $sformatf("%b%b%b%b%b", dp, dn, oe, busy, tx_ready);
  endfunction

  function automatic string sym();
    if (dp && !dn) return "J";
    else if (!dp && dn) return "K";
    else if (!dp && !dn) return "0";
    else return "1";
  endfunction

  // Drives one packet; bytes are offered only when ready is seen, and the line is recorded while oe is high.
  task automatic run_pkt(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input string exp_line, input string exp_rdy);
    logic [7:0] bq [3];
    string line;
    string rdy;
    int    k;
    int    bad;
    bit    seen;
    bit    done;
    bq[0] = b0; bq[1] = b1; bq[2] = b2;
    line = ""; rdy = ""; k = 0; bad = 0; seen = 1'b0; done = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (busy != oe) bad++;
      if (dp && dn) bad++;
      if (oe) begin
        seen = 1'b1;
        line = {line, sym()};
        rdy  = {rdy, tx_ready ? "^" : "."};
        if (tx_ready) begin
          if (k < n) begin
            tx_data  = bq[k];
            tx_valid = 1'b1;
            k++;
          end else begin
            tx_valid = 1'b0;
            tx_data  = 8'hC3;
          end
        end
      end else if (seen) begin
        done = 1'b1;
      end
    end
    tx_valid = 1'b0;
    check({tag, " finished"}, done ? "1" : "0", "1");
    check({tag, " line"}, line, exp_line);
    check({tag, " ready"}, rdy, exp_rdy);
    check({tag, " sanity"}, $sformatf("%0d", bad), "0");
    check({tag, " idle after"}, status(), "10000");
  endtask

  localparam string SYNC_L = "KJKJKJKK";
  localparam string SYNC_R = ".......^";

  initial begin
    string line;
    int    diffs;
    int    k;
    logic [7:0] bq [2];
    clk = 1'b0; rst_n = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    n_checks = 0; n_errors = 0;

    // Async reset before any clock edge.
    #1 rst_n = 1'b0;
    #2 check("reset values", status(), "10000");
    @(negedge clk);
    rst_n = 1'b1;
    diffs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (status() != "10000") diffs++;
    end
    check("idle 10 cycles", $sformatf("%0d", diffs), "0");

    run_pkt("byte 00", 1, 8'h00, 8'h00, 8'h00,
            {SYNC_L, "JKJKJKJK", "00J"}, {SYNC_R, ".......^", "..."});
    run_pkt("byte FF", 1, 8'hFF, 8'h00, 8'h00,
            {SYNC_L, "KKKKKJJJJ", "00J"}, {SYNC_R, "........^", "..."});
    run_pkt("byte FC", 1, 8'hFC, 8'h00, 8'h00,
            {SYNC_L, "JKKKKKKKJ", "00J"}, {SYNC_R, ".......^.", "..."});
    run_pkt("empty", 0, 8'h00, 8'h00, 8'h00,
            {SYNC_L, "00J"}, {SYNC_R, "..."});
    run_pkt("b2b A5 5A FF", 3, 8'hA5, 8'h5A, 8'hFF,
            {SYNC_L, "KJJKJJKK", "JJKKKJJK", "KKKKKKJJJ", "00J"},
            {SYNC_R, ".......^", ".......^", "........^", "..."});
    run_pkt("FC then 00", 2, 8'hFC, 8'h00, 8'h00,
            {SYNC_L, "JKKKKKKKJ", "KJKJKJKJ", "00J"},
            {SYNC_R, ".......^.", ".......^", "..."});

    // Abort during bit 3 of the second byte.
    bq[0] = 8'hA5; bq[1] = 8'h5A;
    line = ""; k = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      line = {line, oe ? sym() : "-"};
      if (tx_ready) begin
        if (k < 2) begin
          tx_data = bq[k];
          k++;
        end else begin
          tx_valid = 1'b0;
        end
      end
    end
    check("pre-abort line", line, {SYNC_L, "KJJKJJKK", "JJKK"});
    #2 rst_n = 1'b0;
    tx_valid = 1'b0;
    #1 check("async abort", status(), "10000");
    diffs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (status() != "10000") diffs++;
    end
    check("no eop in reset", $sformatf("%0d", diffs), "0");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after abort", status(), "10000");
    run_pkt("after abort", 1, 8'h00, 8'h00, 8'h00,
            {SYNC_L, "JKJKJKJK", "00J"}, {SYNC_R, ".......^", "..."});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
